shader_instruction_fetch: RTL and testbench

Instruction fetch/issue sequencer for the vertex shader core: on a start pulse it walks a vertex program in synchronous program memory and presents one instruction per cycle to the shader instruction decoder over a valid/ready handshake. A 2-entry buffer absorbs the 1-cycle memory latency so downstream back-pressure never drops or duplicates an instruction. Fetch stops at the programmed length or at the first END opcode, whichever comes first.

---
 rtl/shader_instruction_fetch.sv | 121 ++++++++++++
 tb/tb_shader_instruction_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shader_instruction_fetch.sv
// Instruction fetch/issue sequencer: walks a vertex program in synchronous program
// memory and presents one instruction per cycle to the decoder through a 2-entry buffer.
module shader_instruction_fetch #(
  parameter int                     INST_WIDTH = 64,
  parameter int                     PC_WIDTH   = 8,
  parameter int                     OP_MSB     = 63,
  parameter int                     OP_LSB     = 56,
  parameter logic [OP_MSB-OP_LSB:0] END_OP     = 8'hFF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  iStart,
  input  logic [PC_WIDTH-1:0]   iStartPC,
  input  logic [PC_WIDTH:0]     iLength,
  input  logic                  iFlush,
  output logic                  oMemRead,
  output logic [PC_WIDTH-1:0]   oMemAddr,
  input  logic [INST_WIDTH-1:0] iMemData,
  output logic                  oValid,
  output logic [INST_WIDTH-1:0] oInstruction,
  output logic [PC_WIDTH-1:0]   oPC,
  input  logic                  iReady,
  output logic                  oBusy,
  output logic                  oDone
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                r_state, w_next_state;
  logic [PC_WIDTH-1:0]   r_pc, r_inflight_pc;
  logic [PC_WIDTH:0]     r_remaining;
  logic                  r_inflight, r_done;
  logic [1:0]            r_count;
  logic [INST_WIDTH-1:0] r_buf_data [2];
  logic [PC_WIDTH-1:0]   r_buf_pc   [2];

  logic       w_pop, w_push, w_end_ret, w_credit, w_issue, w_wr_idx;
  logic [1:0] w_count_after_pop;

  assign w_pop             = (r_count != 2'd0) && iReady;
  assign w_push            = r_inflight;
  assign w_end_ret         = r_inflight && (iMemData[OP_MSB:OP_LSB] == END_OP);
  // Memory latency is one cycle, so at most one read is ever in flight.
  assign w_credit          = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_issue           = (r_state == S_FETCH) && (r_remaining != '0) && w_credit && !iFlush;
  assign w_count_after_pop = r_count - {1'b0, w_pop};
  assign w_wr_idx          = w_count_after_pop[0];

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (iStart && (iLength != '0)) w_next_state = S_FETCH;
      S_FETCH: if ((w_issue && (r_remaining == (PC_WIDTH+1)'(1))) || w_end_ret)
                 w_next_state = S_DRAIN;
      S_DRAIN: if (!r_inflight && (w_count_after_pop == 2'd0)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (iFlush) w_next_state = S_IDLE;
  end

  always_comb begin
    oMemRead     = w_issue;
    oMemAddr     = r_pc;
    oValid       = (r_count != 2'd0);
    oInstruction = r_buf_data[0];
    oPC          = r_buf_pc[0];
    oBusy        = (r_state != S_IDLE);
    oDone        = r_done;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc          <= '0;
      r_inflight_pc <= '0;
      r_remaining   <= '0;
      r_inflight    <= 1'b0;
      r_done        <= 1'b0;
      r_count       <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else begin
      r_done <= !iFlush &&
                (((r_state == S_IDLE) && iStart && (iLength == '0)) ||
                 ((r_state == S_DRAIN) && (w_next_state == S_IDLE)));
      if (iFlush) begin
        r_count    <= '0;
        r_inflight <= 1'b0;
      end else begin
        if ((r_state == S_IDLE) && iStart) begin
          r_pc        <= iStartPC;
          r_remaining <= iLength;
        end
        if (w_issue) begin
          r_pc          <= r_pc + PC_WIDTH'(1);
          r_remaining   <= r_remaining - (PC_WIDTH+1)'(1);
          r_inflight_pc <= r_pc;
        end
        // A read issued in the same cycle an END word returns is dropped here.
        r_inflight <= w_issue && !w_end_ret;
        if (w_pop) begin
          r_buf_data[0] <= r_buf_data[1];
          r_buf_pc[0]   <= r_buf_pc[1];
        end
        // Push lands after the shift, so a simultaneous pop+push at occupancy 1 refills slot 0.
        if (w_push) begin
          r_buf_data[w_wr_idx] <= iMemData;
          r_buf_pc[w_wr_idx]   <= r_inflight_pc;
        end
        r_count <= w_count_after_pop + {1'b0, w_push};
      end
    end
  end

endmodule

// File: tb/tb_shader_instruction_fetch.sv
// Self-checking bench for shader_instruction_fetch: synchronous memory model, ready
// patterns, and a program-walk reference model compared against the delivered stream.
module tb_shader_instruction_fetch;

  logic        clk = 1'b0, resetn = 1'b0, iStart = 1'b0, iFlush = 1'b0, iReady = 1'b0;
  logic [7:0]  iStartPC = '0;
  logic [8:0]  iLength  = '0;
  logic [63:0] iMemData = '0;
  logic        oMemRead, oValid, oBusy, oDone;
  logic [7:0]  oMemAddr, oPC;
  logic [63:0] oInstruction;

  logic [63:0] mem [256];
  int cyc = 0, checks = 0, errors = 0, rmode = 0, phase = 0;
  int issued = 0, accepted = 0, stall_err = 0, ovf_err = 0;
  logic [7:0]  rd_log [$];
  logic [7:0]  acc_pc [$];
  logic [63:0] acc_ins [$];
  int          acc_cyc [$];
  int          done_log [$];
  logic        busy_at_done = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_exempt = 1'b1;
  logic [7:0]  prev_pc = '0;
  logic [63:0] prev_ins = '0;

  shader_instruction_fetch #(
    .INST_WIDTH(64), .PC_WIDTH(8), .OP_MSB(63), .OP_LSB(56), .END_OP(8'hFF)
  ) dut (
    .clk(clk), .resetn(resetn), .iStart(iStart), .iStartPC(iStartPC), .iLength(iLength),
    .iFlush(iFlush), .oMemRead(oMemRead), .oMemAddr(oMemAddr), .iMemData(iMemData),
    .oValid(oValid), .oInstruction(oInstruction), .oPC(oPC), .iReady(iReady),
    .oBusy(oBusy), .oDone(oDone)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  initial forever begin
    @(posedge clk); #1;
    phase = phase + 1;
    case (rmode)
      0:       iReady = 1'b1;
      1:       iReady = 1'b0;
      2:       iReady = (phase % 3 == 0);
      default: iReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Synchronous program memory: data valid the cycle after the read strobe.
  initial begin : memdrv
    logic       rd;
    logic [7:0] ad;
    forever begin
      @(negedge clk); rd = oMemRead; ad = oMemAddr;
      @(posedge clk); #1;
      iMemData = rd ? mem[ad] : {$urandom, $urandom};
    end
  end

  initial forever begin
    @(negedge clk);
    if (resetn) begin
      if (oMemRead) begin rd_log.push_back(oMemAddr); issued = issued + 1; end
      if (oValid && iReady) begin
        acc_pc.push_back(oPC); acc_ins.push_back(oInstruction); acc_cyc.push_back(cyc);
        accepted = accepted + 1;
      end
      if (prev_valid && !prev_ready && !prev_exempt &&
          (!oValid || oPC !== prev_pc || oInstruction !== prev_ins)) stall_err = stall_err + 1;
      if (issued - accepted > 2) ovf_err = ovf_err + 1;
      if (oDone) begin done_log.push_back(cyc); busy_at_done = oBusy; end
    end
    prev_valid = oValid; prev_ready = iReady; prev_pc = oPC; prev_ins = oInstruction;
    prev_exempt = iFlush || !resetn;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rd_log.delete(); acc_pc.delete(); acc_ins.delete(); acc_cyc.delete(); done_log.delete();
    issued = 0; accepted = 0; stall_err = 0; ovf_err = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom, $urandom};
      if (mem[i][63:56] == 8'hFF) mem[i][63:56] = 8'h00;
    end
  endtask

  task automatic start_prog(input logic [7:0] pc, input logic [8:0] len, output int c0);
    @(posedge clk); #1;
    clear_logs();
    iStart = 1'b1; iStartPC = pc; iLength = len; c0 = cyc;
    @(posedge clk); #1;
    iStart = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_log.size() == 0 && n < budget) begin @(posedge clk); n++; end
    checks++;
    if (done_log.size() == 0) begin
      errors++;
      $display("FAIL %s_done_timeout: got no oDone in %0d cycles, required one", name, budget);
    end
    repeat (3) @(posedge clk);
  endtask

  // Reference: walk the program from the start address, stop at length or first END word.
  task automatic check_seq(input string name, input logic [7:0] spc, input int len);
    logic [7:0]  epc [$];
    logic [63:0] eins [$];
    logic [7:0]  a;
    for (int i = 0; i < len; i++) begin
      a = spc + 8'(i);
      epc.push_back(a); eins.push_back(mem[a]);
      if (mem[a][63:56] == 8'hFF) break;
    end
    checks++;
    if (acc_pc.size() !== epc.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d instructions, required %0d", name, acc_pc.size(), epc.size());
    end
    for (int i = 0; i < epc.size() && i < acc_pc.size(); i++) begin
      checks++;
      if (acc_pc[i] !== epc[i] || acc_ins[i] !== eins[i]) begin
        errors++;
        $display("FAIL %s_item%0d: got pc %h ins %h, required pc %h ins %h",
                 name, i, acc_pc[i], acc_ins[i], epc[i], eins[i]);
      end
    end
    checks++;
    if (done_log.size() !== 1) begin
      errors++;
      $display("FAIL %s_done_pulses: got %0d, required 1", name, done_log.size());
    end else if (acc_cyc.size() > 0) begin
      checks++;
      if (done_log[0] !== acc_cyc[acc_cyc.size()-1] + 1) begin
        errors++;
        $display("FAIL %s_done_cycle: got %0d, required %0d", name, done_log[0],
                 acc_cyc[acc_cyc.size()-1] + 1);
      end
      checks++;
      if (busy_at_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_at_done: got %b, required 0", name, busy_at_done);
      end
    end
    checks++;
    if (stall_err !== 0 || ovf_err !== 0) begin
      errors++;
      $display("FAIL %s_hold_credit: got %0d unstable stalls, %0d overflows, required 0 and 0",
               name, stall_err, ovf_err);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({oMemRead, oValid, oBusy, oDone} !== 4'b0 || oMemAddr !== 8'h00 ||
        oPC !== 8'h00 || oInstruction !== 64'h0) begin
      errors++;
      $display("FAIL %s: got rd %b v %b busy %b done %b addr %h pc %h ins %h, required all 0",
               name, oMemRead, oValid, oBusy, oDone, oMemAddr, oPC, oInstruction);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1; resetn = 1'b1;
  endtask

  task automatic test_basic();
    int c0;
    for (int i = 0; i < 256; i++) mem[i] = 64'(i);
    rmode = 0;
    start_prog(8'h10, 9'd4, c0);
    wait_done("basic", 50);
    check_seq("basic", 8'h10, 4);
    for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] !== c0 + 3 + i) begin
        errors++;
        $display("FAIL basic_valid_cycle%0d: got %0d, required %0d", i, acc_cyc[i] - c0, 3 + i);
      end
    end
    checks++;
    if (done_log.size() > 0 && done_log[0] !== c0 + 7) begin
      errors++;
      $display("FAIL basic_done_at7: got %0d, required 7", done_log[0] - c0);
    end
  endtask

  task automatic test_stall();
    int c0;
    rmode = 2;
    start_prog(8'h10, 9'd4, c0);
    wait_done("stall", 80);
    check_seq("stall", 8'h10, 4);
  endtask

  task automatic test_end();
    int c0;
    fill_mem();
    mem[8'h12] = {8'hFF, 56'h12};
    rmode = 0;
    start_prog(8'h10, 9'd8, c0);
    wait_done("endop", 50);
    check_seq("endop", 8'h10, 8);
  endtask

  task automatic test_wrap();
    int c0;
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    fill_mem();
    rmode = 0;
    start_prog(8'hFE, 9'd4, c0);
    wait_done("wrap", 50);
    check_seq("wrap", 8'hFE, 4);
    checks++;
    if (rd_log.size() !== 4) begin
      errors++;
      $display("FAIL wrap_reads: got %0d reads, required 4", rd_log.size());
    end
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d: got %h, required %h", i, rd_log[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_flush();
    int c0;
    fill_mem();
    rmode = 1;
    start_prog(8'h50, 9'd6, c0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (oValid !== 1'b1 || oPC !== 8'h50) begin
      errors++;
      $display("FAIL flush_prefill: got v %b pc %h, required v 1 pc 50", oValid, oPC);
    end
    iFlush = 1'b1;
    @(posedge clk); #1; iFlush = 1'b0;
    @(negedge clk);
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got v %b busy %b, required 0 0", oValid, oBusy);
    end
    repeat (6) @(posedge clk);
    checks++;
    if (done_log.size() !== 0) begin
      errors++;
      $display("FAIL flush_nodone: got %0d oDone pulses, required 0", done_log.size());
    end
    rmode = 0;
    start_prog(8'h60, 9'd3, c0);
    wait_done("after_flush", 50);
    check_seq("after_flush", 8'h60, 3);
  endtask

  task automatic test_reset_mid();
    int c0;
    int bad = 0;
    fill_mem();
    rmode = 0;
    start_prog(8'h30, 9'd6, c0);
    repeat (3) @(posedge clk);
    #1; resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_mid");
    @(posedge clk); #1; resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (oValid || oDone || oBusy || oMemRead) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_start_ignored();
    int c0;
    fill_mem();
    rmode = 2;
    start_prog(8'h20, 9'd4, c0);
    @(posedge clk); #1;
    iStart = 1'b1; iStartPC = 8'h40; iLength = 9'd2;
    @(posedge clk); #1; iStart = 1'b0;
    wait_done("start_ignored", 80);
    check_seq("start_ignored", 8'h20, 4);
  endtask

  task automatic test_len0();
    int c0;
    rmode = 0;
    start_prog(8'h05, 9'd0, c0);
    repeat (4) @(posedge clk);
    checks++;
    if (done_log.size() !== 1 || rd_log.size() !== 0) begin
      errors++;
      $display("FAIL len0: got %0d done pulses, %0d reads, required 1 and 0",
               done_log.size(), rd_log.size());
    end else begin
      checks++;
      if (done_log[0] !== c0 + 1) begin
        errors++;
        $display("FAIL len0_cycle: got %0d, required 1", done_log[0] - c0);
      end
    end
  endtask

  task automatic test_random();
    int c0, len;
    logic [7:0] spc;
    for (int t = 0; t < 8; t++) begin
      fill_mem();
      spc = 8'($urandom);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) mem[8'(spc + 8'($urandom_range(0, 11)))][63:56] = 8'hFF;
      rmode = 3;
      start_prog(spc, 9'(len), c0);
      wait_done("random", 300);
      check_seq("random", spc, len);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_end();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_start_ignored();
    test_len0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
